// File: rtl/gi_masked_sched.sv
// gi_masked_sched: shares one gi_prime masked-monomial stage among NREQ requesters.
// A round-robin arbiter grants one requester per cycle. Each accepted request gets a fresh
// 15-bit mask from an internal LFSR. The result passes through two register stages and
// leaves on a valid/ready port together with its mask and the requester index.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid                      [NREQ]
//   req_data   4-bit operand per requester, lane i at [4i+3:4i] [4*NREQ]
//   req_ready  one-hot grant, combinational                     [NREQ]
//   seed_load  request to reload the LFSR (suppresses grants)
//   seed_val   new LFSR value (zero maps to 15'h0001)           [15]
//   seed_ack   high in the cycle the seed is applied
//   out_valid  result valid
//   out_ready  downstream accept
//   out_data   masked monomial vector                           [15]
//   out_rnd    mask used for this result                        [15]
//   out_id     index of the served requester                    [IDW]
//   busy       high while either pipeline stage holds data
module gi_masked_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter logic [14:0] SEED_RST = 15'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              seed_load,
  input  logic [14:0]       seed_val,
  output logic              seed_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [14:0]       out_data,
  output logic [14:0]       out_rnd,
  output logic [IDW-1:0]    out_id,
  output logic              busy
);

  // Monomials of {a,b,c,d} = x[3:0]: singles, pairs, triples, quadruple, each masked.
  function automatic logic [14:0] gi_prime(input logic [3:0] x, input logic [14:0] rnd);
    logic a, b, c, d;
    logic [14:0] m;
    a = x[3];
    b = x[2];
    c = x[1];
    d = x[0];
    m[0]  = a;
    m[1]  = b;
    m[2]  = c;
    m[3]  = d;
    m[4]  = a & b;
    m[5]  = a & c;
    m[6]  = a & d;
    m[7]  = b & c;
    m[8]  = b & d;
    m[9]  = c & d;
    m[10] = a & b & c;
    m[11] = a & b & d;
    m[12] = a & c & d;
    m[13] = b & c & d;
    m[14] = a & b & c & d;
    return m ^ rnd;
  endfunction

  logic [14:0]     lfsr_q;
  logic [IDW-1:0]  ptr_q;

  logic            a_valid_q;
  logic [3:0]      a_inp_q;
  logic [14:0]     a_rnd_q;
  logic [IDW-1:0]  a_id_q;

  logic            b_valid_q;
  logic [14:0]     b_data_q;
  logic [14:0]     b_rnd_q;
  logic [IDW-1:0]  b_id_q;

  logic            b_load;
  logic            grant_ok;
  logic            seed_apply;
  logic            transfer;
  logic            found;
  logic [NREQ-1:0] rot;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant;
  logic [3:0]      sel_data;

  assign busy       = a_valid_q | b_valid_q;
  assign b_load     = ~b_valid_q | out_ready;
  // Stage A can take a new entry when empty or when it is moving into stage B.
  assign grant_ok   = ~rst & ~seed_load & (~a_valid_q | b_load);
  assign seed_apply = ~rst & seed_load & ~busy;
  assign seed_ack   = seed_apply;

  // Round-robin search: rotate so the pointer sits at bit 0, take the lowest set bit.
  always_comb begin
    rot       = NREQ'({req_valid, req_valid} >> ptr_q);
    found     = 1'b0;
    sum       = '0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) begin
          sum = sum - (IDW+1)'(NREQ);
        end
        grant_idx = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant    = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant[i] = grant_ok & found & (grant_idx == IDW'(i));
      if (grant_idx == IDW'(i)) begin
        sel_data = req_data[4*i +: 4];
      end
    end
  end

  assign req_ready = grant;
  assign transfer  = |grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= SEED_RST;
      ptr_q     <= '0;
      a_valid_q <= 1'b0;
      a_inp_q   <= '0;
      a_rnd_q   <= '0;
      a_id_q    <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_rnd_q   <= '0;
      b_id_q    <= '0;
    end else begin
      // Grants are suppressed while seed_load is high, so the two branches never collide.
      if (seed_apply) begin
        lfsr_q <= (seed_val == 15'h0000) ? 15'h0001 : seed_val;
      end else if (transfer) begin
        lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
      end

      if (transfer) begin
        ptr_q <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      if (b_load) begin
        b_valid_q <= a_valid_q;
        if (a_valid_q) begin
          b_data_q <= gi_prime(a_inp_q, a_rnd_q);
          b_rnd_q  <= a_rnd_q;
          b_id_q   <= a_id_q;
        end
      end

      if (transfer) begin
        a_valid_q <= 1'b1;
        a_inp_q   <= sel_data;
        a_rnd_q   <= lfsr_q;
        a_id_q    <= grant_idx;
      end else if (b_load) begin
        a_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = b_valid_q;
  assign out_data  = b_data_q;
  assign out_rnd   = b_rnd_q;
  assign out_id    = b_id_q;

endmodule

// File: tb/tb_gi_masked_sched.sv
// Self-checking bench for gi_masked_sched: directed scenarios plus random traffic,
// scored against a queue-based reference model by an independent output monitor.
module tb_gi_masked_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [14:0] SEED = 15'h0001;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              seed_load;
  logic [14:0]       seed_val;
  logic              seed_ack;
  logic              out_valid;
  logic              out_ready;
  logic [14:0]       out_data;
  logic [14:0]       out_rnd;
  logic [IDW-1:0]    out_id;
  logic              busy;

  always #5 clk = ~clk;

  gi_masked_sched #(.NREQ(NREQ), .IDW(IDW), .SEED_RST(SEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .seed_ack  (seed_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rnd   (out_rnd),
    .out_id    (out_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each output bit is the product of a subset of {a,b,c,d} (a = x[3]),
  // listed by subset size, then lexicographically, XOR the matching mask bit.
  function automatic logic [14:0] gi_ref(input logic [3:0] x, input logic [14:0] rnd);
    logic [3:0] sub [15];
    logic [14:0] r;
    sub = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'hA, 4'h9, 4'h6, 4'h5, 4'h3,
            4'hE, 4'hD, 4'hB, 4'h7, 4'hF};
    for (int k = 0; k < 15; k++) r[k] = ((x & sub[k]) == sub[k]);
    return r ^ rnd;
  endfunction

  function automatic logic [14:0] lfsr_step(input logic [14:0] v);
    return 15'((v << 1) | (((v >> 14) ^ (v >> 13)) & 15'h1));
  endfunction

  typedef struct {
    logic [14:0] data;
    logic [14:0] rnd;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          in_flight;
  int          ptr;
  logic [14:0] lfsr;
  logic        seen_ack;
  logic [14:0] rnd_log[$];

  // One clock of stimulus: model and grant checks at negedge, then return at posedge+1.
  task automatic cycle();
    logic [NREQ-1:0] exp_ready;
    logic ok;
    logic exp_ack;
    int gidx;
    @(negedge clk);
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'h0);
      in_flight = 0;
      q.delete();
      lfsr = SEED;
      ptr = 0;
      seen_ack = 1'b0;
    end else begin
      exp_ready = '0;
      gidx = 0;
      ok = !seed_load && (in_flight < 2 || out_ready);
      if (ok) begin
        for (int k = 0; k < NREQ; k++) begin
          if (exp_ready == '0 && req_valid[(ptr + k) % NREQ]) begin
            gidx = (ptr + k) % NREQ;
            exp_ready[gidx] = 1'b1;
          end
        end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(in_flight != 0));
      exp_ack = seed_load && in_flight == 0;
      chk("seed_ack", 32'(seed_ack), 32'(exp_ack));
      seen_ack = exp_ack;
      if (out_valid && out_ready) in_flight--;
      if (exp_ready != '0) begin
        q.push_back('{data: gi_ref(req_data[4*gidx +: 4], lfsr), rnd: lfsr, id: gidx});
        lfsr = lfsr_step(lfsr);
        ptr = (gidx + 1) % NREQ;
        in_flight++;
      end
      if (exp_ack) lfsr = (seed_val == 15'h0) ? 15'h0001 : seed_val;
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every accepted result, checks holds under stall.
  logic           hold = 1'b0;
  logic [14:0]    hd, hr;
  logic [IDW-1:0] hid;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 32'(out_valid), 32'h1);
        chk("stall_data", 32'(out_data), 32'(hd));
        chk("stall_rnd", 32'(out_rnd), 32'(hr));
        chk("stall_id", 32'(out_id), 32'(hid));
      end
      hold = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got id %0d with empty scoreboard at %0t", out_id, $time);
          end else begin
            e = q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_rnd", 32'(out_rnd), 32'(e.rnd));
            chk("out_id", 32'(out_id), 32'(e.id));
            rnd_log.push_back(out_rnd);
          end
        end else begin
          hold = 1'b1;
          hd = out_data;
          hr = out_rnd;
          hid = out_id;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int dups;
    logic [14:0] sv;
    in_flight = 0;
    ptr = 0;
    lfsr = SEED;
    seen_ack = 1'b0;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    seed_load = 1'b0;
    seed_val = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_rnd", 32'(out_rnd), 32'h0);
    chk("rst_out_id", 32'(out_id), 32'h0);
    chk("rst_seed_ack", 32'(seed_ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);

    // First transaction and its two-cycle latency.
    out_ready = 1'b1;
    req_valid = 4'b0001;
    req_data = '0;
    #1;
    chk("t1_grant", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    cycle();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(out_data), 32'h0001);
    chk("t1_rnd", 32'(out_rnd), 32'h0001);
    chk("t1_id", 32'(out_id), 32'h0);
    cycle();

    // Back-to-back from requester 0.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = 4'b0001;
    req_data = 16'h0000;
    cycle();
    req_data = 16'h000F;
    cycle();
    req_valid = '0;
    cycle();
    chk("b2b_data", 32'(out_data), 32'h7FFD);
    chk("b2b_rnd", 32'(out_rnd), 32'h0002);
    cycle();

    // All requesters active: strict rotation, distinct masks.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    rnd_log.delete();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      req_data = 16'($urandom);
      #1;
      chk("rr_order", 32'(req_ready), 32'(1 << (i % 4)));
      cycle();
    end
    req_valid = '0;
    repeat (3) cycle();
    chk("rr_count", 32'(rnd_log.size()), 32'd8);
    dups = 0;
    for (int i = 0; i < rnd_log.size(); i++)
      for (int j = i + 1; j < rnd_log.size(); j++)
        if (rnd_log[i] == rnd_log[j]) dups++;
    chk("rr_distinct", 32'(dups), 32'h0);

    // Full pipeline held for 5 cycles, then drained.
    out_ready = 1'b0;
    req_valid = 4'hF;
    repeat (7) begin
      req_data = 16'($urandom);
      cycle();
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("stall_drain", 32'(q.size()), 32'h0);

    // Seed load while busy, for a zero seed and a nonzero seed.
    for (int s = 0; s < 2; s++) begin
      sv = (s == 0) ? 15'h0000 : 15'h1234;
      out_ready = 1'b0;
      req_valid = 4'hF;
      repeat (2) begin
        req_data = 16'($urandom);
        cycle();
      end
      req_valid = '0;
      seed_load = 1'b1;
      seed_val = sv;
      repeat (2) cycle();
      out_ready = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
        cycle();
        got = seen_ack;
      end
      chk("seed_ack_seen", 32'(got), 32'h1);
      seed_load = 1'b0;
      req_valid = 4'b0100;
      req_data = 16'h0500;
      cycle();
      req_valid = '0;
      cycle();
      chk("seed_rnd", 32'(out_rnd), (s == 0) ? 32'h0001 : 32'h1234);
      cycle();
    end

    // Reset with both stages full.
    out_ready = 1'b0;
    req_valid = 4'hF;
    repeat (2) cycle();
    rst = 1'b1;
    req_valid = '0;
    cycle();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    out_ready = 1'b1;
    req_valid = 4'b0010;
    req_data = 16'h0030;
    cycle();
    req_valid = '0;
    cycle();
    chk("mid_rst_rnd", 32'(out_rnd), 32'(SEED));
    cycle();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(99) == 0);
      req_valid = NREQ'($urandom);
      req_data = 16'($urandom);
      out_ready = ($urandom_range(3) != 0);
      seed_load = ($urandom_range(29) == 0);
      seed_val = ($urandom_range(3) == 0) ? 15'h0 : 15'($urandom);
      cycle();
    end
    rst = 1'b0;
    seed_load = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (6) cycle();
    chk("final_empty", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gi_masked_sched.md
Name: gi_masked_sched

Overview:
- Schedules a single shared gi_prime masked-monomial stage among NREQ requesters.
- Round-robin arbitration picks one requester per cycle.
- Every evaluation gets a fresh 15-bit mask from an internal LFSR; masks are never reused.
- The result is registered and returned with the requester ID over a valid/ready output.
- Sits between the S-box lane controllers and the second (combining) stage of the two-stage masked AES S-box.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, ID width; must be at least clog2(NREQ).
- SEED_RST, 15'h0001, LFSR value after reset; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  4*NREQ  4-bit input per requester; requester i uses bits [4i+3:4i].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- seed_load  in  1  request to reload the LFSR.
- seed_val  in  15  new LFSR value.
- seed_ack  out  1  one-cycle pulse when a seed is applied.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  15  masked monomial vector from gi_prime.
- out_rnd  out  15  mask used for this result, forwarded for downstream unmasking.
- out_id  out  IDW  index of the requester that was served.
- busy  out  1  high when stage A or stage B holds valid data.

Behaviour:
- Reset:
  - req_ready=0, out_valid=0, out_data=0, out_rnd=0, out_id=0, seed_ack=0, busy=0.
  - LFSR=SEED_RST; round-robin pointer=0; both stages empty.
- Pipeline:
  - Stage A register holds {inp, rnd, id}. gi_prime is evaluated combinationally from stage A.
  - Stage B register holds {gi_out, rnd, id} and drives the out_* ports.
- Latency: a transfer in cycle t gives stage A valid in t+1 and out_valid in t+2.
- Throughput: one result per cycle while out_ready=1.
- Stall rules:
  - Stage B loads when it is empty or out_ready=1.
  - Stage A advances only when stage B loads.
  - A grant may be issued only when stage A is empty or is advancing this cycle.
  - Otherwise req_ready=0.
- out_* stay stable while out_valid=1 and out_ready=0.
- Arbitration:
  - req_ready is combinational from req_valid, the pointer, the stall condition and seed_load.
  - At most one bit of req_ready is high.
  - Search starts at the pointer and wraps from NREQ-1 to 0. The first requester with valid set is granted.
  - On a transfer, the pointer moves to granted index+1, wrapping at NREQ.
  - With no transfer, the pointer holds.
- req_ready is never asserted for a requester whose req_valid is low.
- LFSR:
  - A transfer copies the current LFSR value into stage A rnd.
  - In the same cycle the LFSR updates to {lfsr[13:0], lfsr[14]^lfsr[13]}.
  - The LFSR advances only on transfers.
- Seed handling:
  - While seed_load=1, all grants are suppressed.
  - The seed applies in the first cycle where seed_load=1 and busy=0. In that cycle: LFSR=seed_val, or 15'h0001 if seed_val==0, and seed_ack=1.
  - seed_load held across multiple idle cycles applies once per cycle.
  - The requester must drop seed_load after seed_ack.
- Reset mid-operation: all in-flight results are discarded; no out_valid follows reset.
- gi mapping: {a,b,c,d}=inp[3:0]. Output bits are the 4 singles, 6 pairs, 4 triples and 1 quadruple, each XORed with rnd[k].

Test Plan:
- Reset, then requester 0 sends inp=4'h0 with out_ready=1 -> req_ready[0] high in cycle 0; two cycles later out_valid=1, out_data=15'h0001, out_rnd=15'h0001, out_id=0.
- Back-to-back: first request inp=4'h0, second request inp=4'hF, both from requester 0 -> second result out_data=15'h7FFD, out_rnd=15'h0002.
- All four requesters hold req_valid=1 for 8 cycles with out_ready=1 -> grant order 0,1,2,3,0,1,2,3; out_id follows the same order with 2-cycle latency; all 8 out_rnd values are distinct.
- Pipeline full, out_ready=0 for 5 cycles -> req_ready=0 throughout, out_* stable, LFSR unchanged; on release, results drain in order with no loss or duplication.
- seed_load=1, seed_val=0 while busy -> no seed_ack until drained; then seed_ack pulses and the next out_rnd=15'h0001. Repeat with seed_val=15'h1234 -> next out_rnd=15'h1234.
- rst asserted while both stages are valid -> next cycle out_valid=0 and busy=0; the next request gets out_rnd=SEED_RST.
